// File: rtl/rx_strobe_scheduler.sv
// rx_strobe_scheduler: clock-enable strobes for the receive chain with one-sample symbol-timing adjust.
// Optional build macro RX_SCHED_STATUS_EN keeps live sym_phase/sym_count status; otherwise they read 0.
module rx_strobe_scheduler #(
  parameter int ACC_SYMS  = 64,
  parameter int SYM_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 adj_req,
  input  logic                 adj_dir,
  output logic                 clk_int,
  output logic                 sam_clk,
  output logic                 sym_clk,
  output logic                 clear_accum,
  output logic                 adj_busy,
  output logic                 adj_done,
  output logic                 adj_err,
  output logic [1:0]           sym_phase,
  output logic [SYM_CNT_W-1:0] sym_count
);
  localparam int ACC_W = $clog2(ACC_SYMS);
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  state_t state, state_nx;
  logic [1:0] b;
  logic [2:0] s, term;
  logic [ACC_W-1:0] acc;
  logic dir, active, accept, apply;
  assign active      = state != IDLE;
  assign clk_int     = active & b[0];
  assign sam_clk     = active & (b == 2'd3);
  assign sym_clk     = sam_clk & (s == term);
  assign clear_accum = sym_clk & (acc == ACC_W'(ACC_SYMS - 1));
  assign adj_busy    = state == PEND;
  assign accept      = (state == RUN) & run & adj_req;
  assign apply       = (state == PEND) & run & sym_clk;
  // next state: run low always idles, a request parks in PEND until the next boundary
  always_comb begin
    state_nx = !run ? IDLE : (state == IDLE) ? RUN : accept ? PEND : apply ? RUN : state;
  end
  // sequencing counters; idle keeps them cleared so the entry edge starts from zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      b        <= '0;
      s        <= '0;
      term     <= 3'd3;
      acc      <= '0;
      dir      <= 1'b0;
      adj_done <= 1'b0;
      adj_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      adj_done <= apply;
      adj_err  <= adj_req & ~accept;
      if (accept) dir <= adj_dir;
      if (state == IDLE) begin
        b    <= '0;
        s    <= '0;
        term <= 3'd3;
        acc  <= '0;
      end else if (run) begin
        b <= b + 2'd1;
        if (sam_clk) s <= sym_clk ? 3'd0 : s + 3'd1;
        if (sym_clk) begin
          term <= apply ? (dir ? 3'd2 : 3'd4) : 3'd3;
          acc  <= (acc == ACC_W'(ACC_SYMS - 1)) ? '0 : acc + ACC_W'(1);
        end
      end
    end
  end
`ifdef RX_SCHED_STATUS_EN
  logic [1:0] phase;
  logic [SYM_CNT_W-1:0] cnt;
  // status: symbol count restarts on each run, phase offset survives run cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
      cnt   <= '0;
    end else begin
      if (state == IDLE && run) cnt <= '0;
      else if (sym_clk && run) cnt <= cnt + 1'b1;
      if (apply) phase <= dir ? phase + 2'd1 : phase - 2'd1;
    end
  end
  assign sym_phase = phase;
  assign sym_count = cnt;
`else
  assign sym_phase = '0;
  assign sym_count = '0;
`endif
endmodule

// File: tb/tb_rx_strobe_scheduler.sv
// tb_rx_strobe_scheduler: directed and random stimulus against a time-based model of the strobe schedule.
module tb_rx_strobe_scheduler;
  localparam int ACC = 4;
  localparam int W   = 4;
  logic clk = 0, reset = 0, run = 0, adj_req = 0, adj_dir = 0;
  logic clk_int, sam_clk, sym_clk, clear_accum, adj_busy, adj_done, adj_err;
  logic [1:0] sym_phase;
  logic [W-1:0] sym_count;
  int checks = 0, failures = 0;
  bit m_act, m_busy, m_dir, m_done, m_err;
  int t, nb, m_syms;
  logic [1:0] m_phase;

  rx_strobe_scheduler #(.ACC_SYMS(ACC), .SYM_CNT_W(W)) dut (
    .clk(clk), .reset(reset), .run(run), .adj_req(adj_req), .adj_dir(adj_dir),
    .clk_int(clk_int), .sam_clk(sam_clk), .sym_clk(sym_clk), .clear_accum(clear_accum),
    .adj_busy(adj_busy), .adj_done(adj_done), .adj_err(adj_err),
    .sym_phase(sym_phase), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_act = 0; m_busy = 0; m_dir = 0; m_done = 0; m_err = 0;
    t = 0; nb = 15; m_syms = 0; m_phase = 0;
  endtask

  task automatic check_all();
    bit sy;
    sy = m_act && t == nb;
    chk("clk_int", clk_int, m_act && t % 2 == 1);
    chk("sam_clk", sam_clk, m_act && t % 4 == 3);
    chk("sym_clk", sym_clk, sy);
    chk("clear_accum", clear_accum, sy && m_syms % ACC == ACC - 1);
    chk("adj_busy", adj_busy, m_busy);
    chk("adj_done", adj_done, m_done);
    chk("adj_err", adj_err, m_err);
`ifdef RX_SCHED_STATUS_EN
    chk("sym_phase", sym_phase, m_phase);
    chk("sym_count", sym_count, m_syms % (1 << W));
`else
    chk("sym_phase", sym_phase, 0);
    chk("sym_count", sym_count, 0);
`endif
  endtask

  // Symbol boundaries are tracked as absolute times since entry: 15, then +16, or +12/+20 once after an adjust.
  task automatic model_edge();
    bit sy, ok;
    sy = m_act && t == nb;
    ok = m_act && !m_busy && run;
    m_err = adj_req && !ok;
    m_done = 0;
    if (!m_act) begin
      if (run) begin m_act = 1; t = 0; nb = 15; m_syms = 0; end
    end else if (!run) begin
      m_act = 0; m_busy = 0;
    end else begin
      if (sy) begin
        m_syms++;
        if (m_busy) begin
          nb = t + (m_dir ? 12 : 20);
          m_phase = m_dir ? m_phase + 2'd1 : m_phase - 2'd1;
          m_busy = 0;
          m_done = 1;
        end else nb = t + 16;
      end
      if (adj_req && ok) begin m_busy = 1; m_dir = adj_dir; end
      t++;
    end
  endtask

  task automatic cyc(input bit r, input bit q, input bit d);
    run = r; adj_req = q; adj_dir = d;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    repeat (3) cyc(0, 0, 0);
    reset = 1;
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (100) cyc(1, 0, 0);
    cyc(1, 1, 1);
    repeat (60) cyc(1, 0, 0);
    cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 1);
    repeat (60) cyc(1, 0, 0);
    for (int i = 0; i < 40 && !(m_act && t == nb); i++) cyc(1, 0, 0);
    cyc(1, 1, 1);
    repeat (40) cyc(1, 0, 0);
    for (int i = 0; i < 40 && !(m_act && t == nb); i++) cyc(1, 0, 0);
    cyc(1, 1, 0);
    repeat (50) cyc(1, 0, 0);
    cyc(1, 1, 1);
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    repeat (27) cyc(1, 0, 0);
    #2 reset = 0;
    #1 chk("async_reset_outputs",
           {clk_int, sam_clk, sym_clk, clear_accum, adj_busy, adj_done, adj_err, sym_phase, sym_count}, 0);
    m_reset();
    @(negedge clk);
    cyc(0, 0, 0);
    reset = 1;
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
